// File: rtl/cga_vga_pkg.sv
// Shared constants for the CGA-to-VGA output stage: RGBI bit positions, vsync FSM
// encoding, the brown colour code and 2-bit intensity levels.
package cga_vga_pkg;

    localparam int RGBI_B = 0;
    localparam int RGBI_G = 1;
    localparam int RGBI_R = 2;
    localparam int RGBI_I = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] COLOR_BROWN = 4'b0110;

    localparam logic [1:0] LVL_OFF  = 2'd0;
    localparam logic [1:0] LVL_DIM  = 2'd1;
    localparam logic [1:0] LVL_MID  = 2'd2;
    localparam logic [1:0] LVL_FULL = 2'd3;

    function automatic logic [1:0] chan_level(input logic c, input logic i);
        case ({c, i})
            2'b00:   chan_level = LVL_OFF;
            2'b01:   chan_level = LVL_DIM;
            2'b10:   chan_level = LVL_MID;
            default: chan_level = LVL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/cga_vsync_regen.sv
// Regenerates VGA vsync so it starts and ends on doubled-line (dbl_hsync) boundaries.
// state  | meaning
// IDLE   | waiting for a CRTC vsync rising edge
// ARM    | vsync seen, waiting for the next doubled-line start
// ACTIVE | vga_vsync asserted, counting doubled lines
module cga_vsync_regen
    import cga_vga_pkg::*;
#(
    parameter bit VSYNC_POL   = 1'b0,
    parameter int VSYNC_LINES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic dbl_hsync,
    output logic vga_vsync,
    output logic frame_start
);

    localparam logic [3:0] LAST_LINE = 4'(VSYNC_LINES - 1);

    logic       vs_prev;
    logic       hs_prev;
    logic       vs_rise;
    logic       hs_rise;
    logic [1:0] state;
    logic [3:0] line_cnt;
    logic       start_s1;

    assign vs_rise = vsync & ~vs_prev;
    assign hs_rise = dbl_hsync & ~hs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Track inputs during reset so a level held across release is not an edge,
            // while a low-to-high change in the first clock after release still is.
            vs_prev     <= vsync;
            hs_prev     <= dbl_hsync;
            state       <= ST_IDLE;
            line_cnt    <= 4'd0;
            start_s1    <= 1'b0;
            vga_vsync   <= ~VSYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vs_prev  <= vsync;
            hs_prev  <= dbl_hsync;
            start_s1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vs_rise) state <= ST_ARM;
                end
                ST_ARM: begin
                    if (hs_rise) begin
                        state    <= ST_ACTIVE;
                        line_cnt <= 4'd0;
                        start_s1 <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (hs_rise) begin
                        if (line_cnt == LAST_LINE) state <= ST_IDLE;
                        else line_cnt <= line_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // One extra register so vsync lines up with the 2-stage hsync path.
            vga_vsync   <= (state == ST_ACTIVE) ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= start_s1;
        end
    end

endmodule

// File: rtl/cga_vga_out.sv
// CGA scandoubler output stage: 2-clock RGBI-to-VGA colour pipeline with brown fix,
// polarity-adjusted hsync and line-aligned vsync regeneration.
module cga_vga_out
    import cga_vga_pkg::*;
#(
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int VSYNC_LINES = 4,
    parameter bit BROWN_FIX   = 1'b1,
    parameter bit BLANK_ON_DE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] video,
    input  logic       display_enable,
    input  logic       dbl_hsync,
    input  logic       vsync,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       frame_start
);

    logic [3:0] video_s1;
    logic       de_s1;
    logic       hs_s1;
    logic [1:0] r_d;
    logic [1:0] g_d;
    logic [1:0] b_d;

    always_comb begin
        r_d = chan_level(video_s1[RGBI_R], video_s1[RGBI_I]);
        g_d = chan_level(video_s1[RGBI_G], video_s1[RGBI_I]);
        b_d = chan_level(video_s1[RGBI_B], video_s1[RGBI_I]);
        if (BROWN_FIX && video_s1 == COLOR_BROWN) g_d = LVL_DIM;
        if (BLANK_ON_DE && !de_s1) begin
            r_d = LVL_OFF;
            g_d = LVL_OFF;
            b_d = LVL_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            video_s1  <= 4'd0;
            de_s1     <= 1'b0;
            hs_s1     <= 1'b0;
            vga_r     <= LVL_OFF;
            vga_g     <= LVL_OFF;
            vga_b     <= LVL_OFF;
            vga_hsync <= ~HSYNC_POL;
        end else begin
            video_s1  <= video;
            de_s1     <= display_enable;
            hs_s1     <= dbl_hsync;
            vga_r     <= r_d;
            vga_g     <= g_d;
            vga_b     <= b_d;
            vga_hsync <= hs_s1 ~^ HSYNC_POL;
        end
    end

    cga_vsync_regen #(
        .VSYNC_POL  (VSYNC_POL),
        .VSYNC_LINES(VSYNC_LINES)
    ) u_vsync (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .dbl_hsync  (dbl_hsync),
        .vga_vsync  (vga_vsync),
        .frame_start(frame_start)
    );

endmodule
